dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - processor data-memory port bundle (request lines, readData, stall)
interface dmem_responder_if #(
    parameter int N  = 64,
    parameter int AW = 6
);
    logic          memRead;
    logic          memWrite;
    logic [AW-1:0] address;
    logic [N-1:0]  writeData;
    logic [N-1:0]  readData;
    logic          stall;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, stall
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory with WAIT wait states; DMEM_DUMP_EN adds a sequential dump port
module dmem_responder #(
    parameter int N    = 64,
    parameter int AW   = 6,
    parameter int WAIT = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_responder_if.slave bus,
    input  logic           dump,
    output logic           dump_valid,
    output logic [AW-1:0]  dump_addr,
    output logic [N-1:0]   dump_data
);
    localparam int DEPTH = 2 ** AW;

`ifdef DMEM_DUMP_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DUMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t        state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q;
    logic          req;

    // Contents survive reset; only the declaration clears them.
    logic [N-1:0]  mem [DEPTH] = '{default: '0};

`ifdef DMEM_DUMP_EN
    logic dump_q;
    logic dump_pend;
`else
    logic unused_dump;
    assign unused_dump = dump;
    assign dump_valid  = 1'b0;
    assign dump_addr   = '0;
    assign dump_data   = '0;
`endif

    assign req = bus.memRead | bus.memWrite;

    always_comb begin
        bus.stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    bus.stall = req;
                BUSY:    bus.stall = 1'b1;
`ifdef DMEM_DUMP_EN
                DUMP:    bus.stall = 1'b1;
`endif
                default: bus.stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus.readData <= '0;
`ifdef DMEM_DUMP_EN
            dump_q       <= 1'b0;
            dump_pend    <= 1'b0;
            dump_valid   <= 1'b0;
            dump_addr    <= '0;
            dump_data    <= '0;
`endif
        end else begin
`ifdef DMEM_DUMP_EN
            dump_q <= dump;
            if (dump && !dump_q)
                dump_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= bus.memWrite;
                        addr_q   <= bus.address;
                        wdata_q  <= bus.writeData;
                        cnt      <= (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
                        // With no wait states the access happens on the accepting edge.
                        if (WAIT == 0) begin
                            if (bus.memWrite)
                                mem[bus.address] <= bus.writeData;
                            else
                                bus.readData <= mem[bus.address];
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
`ifdef DMEM_DUMP_EN
                    else if (dump_pend) begin
                        dump_pend  <= 1'b0;
                        dump_valid <= 1'b1;
                        dump_addr  <= '0;
                        dump_data  <= mem[0];
                        state      <= DUMP;
                    end
`endif
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (op_write)
                            mem[addr_q] <= wdata_q;
                        else
                            bus.readData <= mem[addr_q];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // The request that just completed is still asserted here; ignore it.
                DONE: state <= IDLE;
`ifdef DMEM_DUMP_EN
                DUMP: begin
                    if (dump_addr == '1) begin
                        dump_valid <= 1'b0;
                        dump_addr  <= '0;
                        dump_data  <= '0;
                        state      <= IDLE;
                    end else begin
                        dump_addr <= dump_addr + 1'b1;
                        dump_data <= mem[dump_addr + 1'b1];
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder (WAIT=2 and WAIT=0 instances)
module tb_dmem_responder;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int WA = 2;
    localparam int WB = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.N(N), .AW(AW)) bus_a ();
    dmem_responder_if #(.N(N), .AW(AW)) bus_b ();

    logic          dump_a, dump_b;
    logic          dv_a, dv_b;
    logic [AW-1:0] da_a, da_b;
    logic [N-1:0]  dd_a, dd_b;

    dmem_responder #(.N(N), .AW(AW), .WAIT(WA)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .dump(dump_a), .dump_valid(dv_a), .dump_addr(da_a), .dump_data(dd_a)
    );

    dmem_responder #(.N(N), .AW(AW), .WAIT(WB)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .dump(dump_b), .dump_valid(dv_b), .dump_addr(da_b), .dump_data(dd_b)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] mem_a [64];
    logic [N-1:0] mem_b [64];
    logic [N-1:0] rd_a, rd_b;

    task automatic drive(input bit b, input bit rd, input bit wr,
                         input logic [AW-1:0] addr, input logic [N-1:0] data);
        if (b) begin
            bus_b.memRead = rd; bus_b.memWrite = wr; bus_b.address = addr; bus_b.writeData = data;
        end else begin
            bus_a.memRead = rd; bus_a.memWrite = wr; bus_a.address = addr; bus_a.writeData = data;
        end
    endtask

    // Presents one request at posedge+1, counts stall cycles up to the first stall-low
    // cycle (DONE), captures readData there, and updates the reference model.
    task automatic access(input bit b, input bit rd, input bit wr,
                          input logic [AW-1:0] addr, input logic [N-1:0] data, input bit rel,
                          output int stalls, output logic [N-1:0] rdata);
        bit   done;
        logic s;
        drive(b, rd, wr, addr, data);
        stalls = 0;
        rdata  = '0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            s = b ? bus_b.stall : bus_a.stall;
            if (s) begin
                stalls++;
                @(posedge clk); #1;
            end else begin
                rdata = b ? bus_b.readData : bus_a.readData;
                done  = 1'b1;
            end
        end
        @(posedge clk); #1;
        if (rel) drive(b, 1'b0, 1'b0, '0, '0);
        if (wr) begin
            if (b) mem_b[addr] = data; else mem_a[addr] = data;
        end else if (rd) begin
            if (b) rd_b = mem_b[addr]; else rd_a = mem_a[addr];
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 6'd3, '0);
        drive(1'b1, 1'b0, 1'b1, 6'd4, 64'h1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_a.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_a: got %b expected 0", bus_a.stall); end
        checks++; if (bus_b.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_b: got %b expected 0", bus_b.stall); end
        checks++; if (bus_a.readData !== 64'h0) begin errors++; $display("FAIL reset_rdata_a: got %h expected 0", bus_a.readData); end
        checks++; if (bus_b.readData !== 64'h0) begin errors++; $display("FAIL reset_rdata_b: got %h expected 0", bus_b.readData); end
        checks++; if ({dv_a, da_a, dd_a} !== '0) begin errors++; $display("FAIL reset_dump: got %b/%0d/%h expected 0/0/0", dv_a, da_a, dd_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rd_a = '0;
        rd_b = '0;
    endtask

    task automatic test_write_read;
        int st;
        logic [N-1:0] rv;
        access(1'b0, 1'b0, 1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001, 1'b1, st, rv);
        checks++; if (st !== WA + 1) begin errors++; $display("FAIL wr5_stall: got %0d expected %0d", st, WA + 1); end
        access(1'b0, 1'b1, 1'b0, 6'd5, '0, 1'b1, st, rv);
        checks++; if (st !== WA + 1) begin errors++; $display("FAIL rd5_stall: got %0d expected %0d", st, WA + 1); end
        checks++; if (rv !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL rd5_data: got %h expected deadbeef00000001", rv); end
    endtask

    task automatic test_back_to_back;
        int st;
        logic [N-1:0] rv;
        logic [N-1:0] v1, v2;
        v1 = {$urandom(), $urandom()};
        v2 = {$urandom(), $urandom()};
        access(1'b1, 1'b0, 1'b1, 6'd1, v1, 1'b1, st, rv);
        access(1'b1, 1'b0, 1'b1, 6'd2, v2, 1'b1, st, rv);
        access(1'b1, 1'b1, 1'b0, 6'd1, '0, 1'b0, st, rv);
        checks++; if (st !== 1) begin errors++; $display("FAIL b2b_rd1_stall: got %0d expected 1", st); end
        checks++; if (rv !== v1) begin errors++; $display("FAIL b2b_rd1_data: got %h expected %h", rv, v1); end
        access(1'b1, 1'b1, 1'b0, 6'd2, '0, 1'b1, st, rv);
        checks++; if (st !== 1) begin errors++; $display("FAIL b2b_rd2_stall: got %0d expected 1", st); end
        checks++; if (rv !== v2) begin errors++; $display("FAIL b2b_rd2_data: got %h expected %h", rv, v2); end
        @(negedge clk);
        checks++; if (bus_b.stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_stall: got %b expected 0", bus_b.stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_rw_both;
        int st;
        logic [N-1:0] rv, prior;
        access(1'b0, 1'b1, 1'b0, 6'd5, '0, 1'b1, st, rv);
        prior = rd_a;
        access(1'b0, 1'b1, 1'b1, 6'd7, 64'h55, 1'b1, st, rv);
        checks++; if (st !== WA + 1) begin errors++; $display("FAIL both_stall: got %0d expected %0d", st, WA + 1); end
        checks++; if (rv !== prior) begin errors++; $display("FAIL both_rdata_kept: got %h expected %h", rv, prior); end
        access(1'b0, 1'b1, 1'b0, 6'd7, '0, 1'b1, st, rv);
        checks++; if (rv !== 64'h55) begin errors++; $display("FAIL both_array7: got %h expected 55", rv); end
    endtask

    task automatic test_reset_mid;
        int st;
        logic [N-1:0] rv, exp9;
        exp9 = mem_a[9];
        drive(1'b0, 1'b0, 1'b1, 6'd9, {$urandom(), $urandom()});
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_a = '0;
        rd_b = '0;
        @(negedge clk);
        checks++; if (bus_a.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", bus_a.stall); end
        checks++; if (bus_a.readData !== 64'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", bus_a.readData); end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 1'b0, 6'd9, '0, 1'b1, st, rv);
        checks++; if (rv !== exp9) begin errors++; $display("FAIL rstmid_array9: got %h expected %h", rv, exp9); end
    endtask

    task automatic test_random;
        int st, op;
        bit b;
        logic [N-1:0] rv, exp_rd;
        logic [AW-1:0] addr;
        for (int i = 0; i < 40; i++) begin
            b    = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 2);
            addr = AW'($urandom_range(0, 63));
            access(b, op != 1, op != 0, addr, {$urandom(), $urandom()}, 1'b1, st, rv);
            exp_rd = b ? rd_b : rd_a;
            checks++; if (st !== (b ? WB : WA) + 1) begin errors++; $display("FAIL rand%0d_stall: got %0d expected %0d", i, st, (b ? WB : WA) + 1); end
            checks++; if (rv !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %h expected %h", i, rv, exp_rd); end
        end
    endtask

`ifdef DMEM_DUMP_EN
    task automatic test_dump;
        int st;
        logic [N-1:0] rv;
        for (int k = 0; k < 4; k++)
            access(1'b0, 1'b0, 1'b1, AW'(k), 64'(10 + k), 1'b1, st, rv);
        dump_a = 1'b1;
        @(posedge clk); #1;
        dump_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10 && dv_a !== 1'b1; i++) @(negedge clk);
        checks++; if (dv_a !== 1'b1) begin errors++; $display("FAIL dump_start: got %b expected 1", dv_a); end
        for (int k = 0; k < 64; k++) begin
            checks++; if (dv_a !== 1'b1) begin errors++; $display("FAIL dump%0d_valid: got %b expected 1", k, dv_a); end
            checks++; if (da_a !== AW'(k)) begin errors++; $display("FAIL dump%0d_addr: got %0d expected %0d", k, da_a, k); end
            checks++; if (dd_a !== mem_a[k]) begin errors++; $display("FAIL dump%0d_data: got %h expected %h", k, dd_a, mem_a[k]); end
            checks++; if (bus_a.stall !== 1'b1) begin errors++; $display("FAIL dump%0d_stall: got %b expected 1", k, bus_a.stall); end
            @(negedge clk);
        end
        checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL dump_end_valid: got %b expected 0", dv_a); end
        checks++; if (bus_a.stall !== 1'b0) begin errors++; $display("FAIL dump_end_stall: got %b expected 0", bus_a.stall); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_dump_off;
        dump_a = 1'b1;
        @(posedge clk); #1;
        dump_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (dv_a !== 1'b0 || bus_a.stall !== 1'b0) begin errors++; $display("FAIL dumpoff%0d: got valid=%b stall=%b expected 0/0", i, dv_a, bus_a.stall); end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        rd_a = '0;
        rd_b = '0;
        dump_a = 1'b0;
        dump_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        test_reset;
        test_write_read;
        test_back_to_back;
        test_rw_both;
        test_reset_mid;
        test_random;
`ifdef DMEM_DUMP_EN
        test_dump;
`else
        test_dump_off;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
